// File: rtl/cordiccart2pol_mul_arbiter_if.sv
// Operand request / tagged result bus between cart2pol requesters and the shared multiplier.
interface cordiccart2pol_mul_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DIN0_WIDTH = 22,
  parameter int DIN1_WIDTH = 24,
  parameter int DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH - 1,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic                          out_valid;
  logic                          out_ready;
  logic [DOUT_WIDTH-1:0]         out_dout;
  logic [ID_WIDTH-1:0]           out_id;
  logic                          busy;

  modport master (
    output req_valid, req_din0, req_din1, out_ready,
    input  req_ready, out_valid, out_dout, out_id, busy
  );

  modport slave (
    input  req_valid, req_din0, req_din1, out_ready,
    output req_ready, out_valid, out_dout, out_id, busy
  );
endinterface

// File: rtl/cordiccart2pol_mul_arbiter.sv
// Round-robin share of one unsigned x signed multiplier; results tagged with requester id.
// Latency 1 into an empty result FIFO; grants stall when the FIFO is full and not popping.

module cordiccart2pol_mul #(
  parameter int DIN0_WIDTH = 22,
  parameter int DIN1_WIDTH = 24,
  parameter int DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH - 1
) (
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout
);
  logic signed [DOUT_WIDTH-1:0] a;
  logic signed [DOUT_WIDTH-1:0] b;

  // din0 is zero-extended, din1 sign-extended; product wraps to DOUT_WIDTH bits
  assign a    = $signed(DOUT_WIDTH'($signed({1'b0, din0})));
  assign b    = $signed(DOUT_WIDTH'($signed(din1)));
  assign dout = a * b;
endmodule

module cordiccart2pol_mul_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DIN0_WIDTH = 22,
  parameter int DIN1_WIDTH = 24,
  parameter int DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH - 1,
  parameter int FIFO_DEPTH = 2,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  cordiccart2pol_mul_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DOUT_WIDTH-1:0] dout;
  } entry_t;

  entry_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [ID_WIDTH-1:0] rr_last;

  logic                grant_vld;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                can_accept;
  logic                push;
  logic                pop;
  logic [DIN0_WIDTH-1:0] sel_din0;
  logic [DIN1_WIDTH-1:0] sel_din1;
  logic [DOUT_WIDTH-1:0] product;

  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_WIDTH'(idx);
      end
    end
  end

  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign can_accept    = (count < CNT_W'(FIFO_DEPTH)) || pop;

  // Reset masks the grant so nothing is accepted during the reset cycle
  always_comb begin
    bus.req_ready = '0;
    if (grant_vld && can_accept && !ap_rst) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  assign push     = |(bus.req_valid & bus.req_ready);
  assign sel_din0 = bus.req_din0[grant_idx*DIN0_WIDTH +: DIN0_WIDTH];
  assign sel_din1 = bus.req_din1[grant_idx*DIN1_WIDTH +: DIN1_WIDTH];

  cordiccart2pol_mul #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (sel_din0),
    .din1 (sel_din1),
    .dout (product)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_last <= ID_WIDTH'(NUM_REQ - 1);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{id: grant_idx, dout: product};
        wr_ptr      <= wr_ptr + 1'b1;
        rr_last     <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_dout = mem[rd_ptr].dout;
  assign bus.out_id   = mem[rd_ptr].id;
  assign bus.busy     = bus.out_valid || (|bus.req_valid);
endmodule
